// File: rtl/hub75_pkg.sv
// Shared types and constants for the HUB75 scan controller.
package hub75_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    LATCH,
    DISPLAY,
    BLANK
  } scan_state_t;

  // Bit positions of each colour inside the frame-buffer pixel pair
  localparam int BIT_R0 = 5;
  localparam int BIT_G0 = 4;
  localparam int BIT_B0 = 3;
  localparam int BIT_R1 = 2;
  localparam int BIT_G1 = 1;
  localparam int BIT_B1 = 0;

endpackage

// File: rtl/hub75_shift_seq.sv
// Slot/phase sequencer for one row shift: COLS+1 two-cycle slots, read column,
// shift clock, colour-capture strobe and end-of-shift flag.
module hub75_shift_seq
  import hub75_pkg::*;
#(
  parameter int COLS  = 64,
  parameter int COL_W = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             active,
  output logic [COL_W-1:0] col,
  output logic             sclk,
  output logic             capture,
  output logic             done
);

  localparam int SLOT_W = $clog2(COLS + 1);

  logic [SLOT_W-1:0] slot;
  logic [SLOT_W-1:0] slot_nxt;
  logic              phase;

  assign slot_nxt = slot + SLOT_W'(1);
  assign capture  = active && phase;
  assign done     = active && phase && (slot == SLOT_W'(COLS));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot  <= '0;
      phase <= 1'b0;
      col   <= '0;
      sclk  <= 1'b0;
    end else if (start) begin
      slot  <= '0;
      phase <= 1'b0;
      col   <= '0;
      sclk  <= 1'b0;
    end else if (active) begin
      if (!phase) begin
        phase <= 1'b1;
        // slot 0 has no sampled column yet, so it produces no shift pulse
        sclk  <= (slot != '0);
      end else begin
        phase <= 1'b0;
        slot  <= slot_nxt;
        sclk  <= 1'b0;
        if (slot < SLOT_W'(COLS - 1)) col <= slot_nxt[COL_W-1:0];
      end
    end
  end

endmodule

// File: rtl/hub75_scan_ctrl.sv
// HUB75 dual-scan panel controller: row FSM, row/display counters and the
// registered panel-side outputs.
module hub75_scan_ctrl
  import hub75_pkg::*;
#(
  parameter int COLS      = 64,
  parameter int COL_W     = $clog2(COLS),
  parameter int ROW_W     = 5,
  parameter int ON_CYCLES = 256
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  output logic [ROW_W+COL_W-1:0] rd_addr,
  input  logic [5:0]             rd_data,
  output logic                   r0,
  output logic                   g0,
  output logic                   b0,
  output logic                   r1,
  output logic                   g1,
  output logic                   b1,
  output logic                   sclk,
  output logic                   lat,
  output logic                   oe_n,
  output logic [ROW_W-1:0]       addr,
  output logic                   busy,
  output logic                   frame_done,
  output scan_state_t            state_dbg
);

  // Frame-buffer port has no valid/ready: it is a fixed-latency read, data for
  // the address presented in cycle N is valid during cycle N+1.

  localparam int ON_W = $clog2(ON_CYCLES + 1);

  scan_state_t      state;
  logic [ROW_W-1:0] row;
  logic [ROW_W-1:0] row_inc;
  logic [ROW_W-1:0] rd_row;
  logic [ON_W-1:0]  on_cnt;
  logic [COL_W-1:0] col;
  logic             start;
  logic             capture;
  logic             shift_done;

  assign row_inc   = row + ROW_W'(1);
  assign start     = enable && (state == IDLE || state == BLANK);
  assign rd_addr   = {rd_row, col};
  assign state_dbg = state;

  hub75_shift_seq #(
    .COLS  (COLS),
    .COL_W (COL_W)
  ) u_seq (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .active  (state == SHIFT),
    .col     (col),
    .sclk    (sclk),
    .capture (capture),
    .done    (shift_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      row        <= '0;
      rd_row     <= '0;
      on_cnt     <= '0;
      lat        <= 1'b0;
      oe_n       <= 1'b1;
      addr       <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      {r0, g0, b0, r1, g1, b1} <= 6'b0;
    end else begin
      frame_done <= 1'b0;
      if (capture) begin
        r0 <= rd_data[BIT_R0];
        g0 <= rd_data[BIT_G0];
        b0 <= rd_data[BIT_B0];
        r1 <= rd_data[BIT_R1];
        g1 <= rd_data[BIT_G1];
        b1 <= rd_data[BIT_B1];
      end
      case (state)
        IDLE: begin
          if (enable) begin
            state  <= SHIFT;
            rd_row <= row;
            busy   <= 1'b1;
          end
        end
        SHIFT: begin
          if (shift_done) begin
            state <= LATCH;
            lat   <= 1'b1;
            addr  <= row;
          end
        end
        LATCH: begin
          state  <= DISPLAY;
          lat    <= 1'b0;
          oe_n   <= 1'b0;
          on_cnt <= '0;
        end
        DISPLAY: begin
          if (on_cnt == ON_W'(ON_CYCLES - 1)) begin
            state <= BLANK;
            oe_n  <= 1'b1;
          end else begin
            on_cnt <= on_cnt + ON_W'(1);
          end
        end
        BLANK: begin
          row        <= row_inc;
          frame_done <= (row_inc == '0);
          if (enable) begin
            state  <= SHIFT;
            rd_row <= row_inc;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hub75_scan_ctrl.sv
// Bench for hub75_scan_ctrl: a panel-side monitor logs rows, pulses and
// addresses; each test compares the logs with a row/frame model of the panel.
module tb_hub75_scan_ctrl;
  import hub75_pkg::*;

  localparam int COLS       = 4;
  localparam int COL_W      = 2;
  localparam int ROW_W      = 2;
  localparam int ON_CYCLES  = 8;
  localparam int ROWS       = 1 << ROW_W;
  localparam int ROW_PERIOD = 2 * (COLS + 1) + ON_CYCLES + 2;
  localparam int FRAME      = ROWS * ROW_PERIOD;
  localparam int DW         = 6 * COLS;
  localparam logic [16:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 2'b0, 6'b0, 4'b0, 1'b0, 1'b0};

  // clock/reset and DUT signals
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic [ROW_W+COL_W-1:0] rd_addr;
  logic [5:0] rd_data = '0;
  logic r0, g0, b0, r1, g1, b1, sclk, lat, oe_n, busy, frame_done;
  logic [ROW_W-1:0] addr;
  scan_state_t state_dbg;
  wire [16:0] outs = {sclk, lat, oe_n, addr, r0, g0, b0, r1, g1, b1, rd_addr, busy, frame_done};

  always #5 clk = ~clk;

  hub75_scan_ctrl #(.COLS(COLS), .COL_W(COL_W), .ROW_W(ROW_W), .ON_CYCLES(ON_CYCLES)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .rd_addr(rd_addr), .rd_data(rd_data),
    .r0(r0), .g0(g0), .b0(b0), .r1(r1), .g1(g1), .b1(b1), .sclk(sclk), .lat(lat),
    .oe_n(oe_n), .addr(addr), .busy(busy), .frame_done(frame_done), .state_dbg(state_dbg)
  );

  // synchronous frame buffer, one cycle read latency
  logic [5:0] mem [ROWS*COLS];
  always @(posedge clk) rd_data <= mem[rd_addr];

  // monitor logs
  typedef struct { int cyc; logic [ROW_W-1:0] addr; int edges; logic [DW-1:0] data; } row_rec_t;
  row_rec_t row_q[$];
  int lat_len_q[$], oe_len_q[$], fd_q[$], busy_rise_q[$], busy_fall_q[$];
  logic [ROW_W+COL_W-1:0] ra_q[$];
  logic [ROW_W+DW-1:0] exp_q[$];
  int cyc = 0;
  int ghost_err, sclk_rises, lat_cycles, oe_low_cycles, busy_cycles;
  int edge_cnt, lat_run, oe_run;
  logic [DW-1:0] shift_data;
  logic p_sclk, p_lat, p_oe_n, p_busy, ra_seen;
  logic [ROW_W-1:0] p_addr;
  logic [ROW_W+COL_W-1:0] p_ra;
  int total = 0;
  int bad = 0;
  int exp_row = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!reset_n) begin
      p_sclk = 1'b0; p_lat = 1'b0; p_oe_n = 1'b1; p_busy = 1'b0; p_addr = '0;
      ra_seen = 1'b0; edge_cnt = 0; lat_run = 0; oe_run = 0; shift_data = '0;
    end else begin
      if (sclk && !p_sclk) begin
        edge_cnt++;
        sclk_rises++;
        shift_data = {shift_data[DW-7:0], r0, g0, b0, r1, g1, b1};
      end
      if (lat) begin lat_run++; lat_cycles++; end
      if (lat && !p_lat) begin
        row_q.push_back('{cyc, addr, edge_cnt, shift_data});
        edge_cnt = 0;
        shift_data = '0;
      end
      if (!lat && p_lat) begin lat_len_q.push_back(lat_run); lat_run = 0; end
      if (!oe_n) begin oe_run++; oe_low_cycles++; end
      else if (!p_oe_n) begin oe_len_q.push_back(oe_run); oe_run = 0; end
      if (addr != p_addr && (!oe_n || !p_oe_n)) ghost_err++;
      if (frame_done) fd_q.push_back(cyc);
      if (busy) busy_cycles++;
      if (busy && !p_busy) busy_rise_q.push_back(cyc);
      if (!busy && p_busy) busy_fall_q.push_back(cyc);
      if (!ra_seen || rd_addr != p_ra) ra_q.push_back(rd_addr);
      ra_seen = 1'b1; p_ra = rd_addr; p_sclk = sclk; p_lat = lat;
      p_oe_n = oe_n; p_busy = busy; p_addr = addr;
    end
  end

  // driver tasks
  task automatic apply_reset();
    enable = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    row_q.delete(); lat_len_q.delete(); oe_len_q.delete(); fd_q.delete();
    busy_rise_q.delete(); busy_fall_q.delete(); ra_q.delete(); exp_q.delete();
    ghost_err = 0; sclk_rises = 0; lat_cycles = 0; oe_low_cycles = 0; busy_cycles = 0;
    exp_row = 0;
  endtask

  // mode 0: every pixel 101010, mode 1: one-hot column index, else random
  task automatic fill_mem(input int mode);
    for (int i = 0; i < ROWS * COLS; i++) begin
      if (mode == 0) mem[i] = 6'b101010;
      else if (mode == 1) mem[i] = 6'(1 << (i % COLS));
      else mem[i] = 6'($urandom);
    end
  endtask

  task automatic wait_rows(input int n, input int budget, input string what);
    int k = 0;
    while (row_q.size() < n && k < budget) begin @(negedge clk); k++; end
    total++;
    if (row_q.size() < n) begin
      bad++;
      $display("FAIL %s_timeout: rows latched=%0d required=%0d", what, row_q.size(), n);
    end
  endtask

  task automatic stop_scan(input string what);
    int k = 0;
    enable = 1'b0;
    @(negedge clk);
    while (busy && k < 4 * ROW_PERIOD) begin @(negedge clk); k++; end
    @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL %s_stop: busy=%b required=0", what, busy);
    end
  endtask

  // reference model: rows latch in order modulo ROWS, shifting columns 0..COLS-1
  task automatic predict_rows(input int n);
    logic [DW-1:0] d;
    for (int k = 0; k < n; k++) begin
      d = '0;
      for (int c = 0; c < COLS; c++) d = {d[DW-7:0], mem[exp_row * COLS + c]};
      exp_q.push_back({ROW_W'(exp_row), d});
      exp_row = (exp_row + 1) % ROWS;
    end
  endtask

  // tests
  task automatic test_reset();
    enable = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (outs !== RESET_VEC || state_dbg !== IDLE) begin
      bad++;
      $display("FAIL reset_values: outs=%b state=%0d required outs=%b state=%0d", outs, state_dbg, RESET_VEC, IDLE);
    end
    apply_reset();
  endtask

  task automatic test_idle();
    apply_reset();
    repeat (100) @(negedge clk);
    total++;
    if (sclk_rises != 0 || lat_cycles != 0 || oe_low_cycles != 0 || busy_cycles != 0) begin
      bad++;
      $display("FAIL idle_quiet: sclk=%0d lat=%0d oe_low=%0d busy=%0d required all 0",
               sclk_rises, lat_cycles, oe_low_cycles, busy_cycles);
    end
  endtask

  task automatic test_const_pattern();
    logic [ROW_W+DW-1:0] e;
    apply_reset();
    fill_mem(0);
    enable = 1'b1;
    wait_rows(4, 6 * ROW_PERIOD, "const");
    stop_scan("const");
    predict_rows(row_q.size());
    foreach (row_q[i]) begin
      e = exp_q.pop_front();
      total++;
      if ({row_q[i].addr, row_q[i].data} !== e || row_q[i].edges != COLS) begin
        bad++;
        $display("FAIL const_row%0d: addr=%0d edges=%0d data=%h required addr=%0d edges=%0d data=%h",
                 i, row_q[i].addr, row_q[i].edges, row_q[i].data, e[ROW_W+DW-1:DW], COLS, e[DW-1:0]);
      end
      if (i > 0) begin
        total++;
        if (row_q[i].cyc - row_q[i-1].cyc != ROW_PERIOD) begin
          bad++;
          $display("FAIL const_period%0d: got %0d required %0d", i, row_q[i].cyc - row_q[i-1].cyc, ROW_PERIOD);
        end
      end
    end
    total++;
    if (lat_len_q.size() != 4 || oe_len_q.size() != 4) begin
      bad++;
      $display("FAIL const_pulse_count: lat=%0d oe=%0d required 4 4", lat_len_q.size(), oe_len_q.size());
    end
    foreach (lat_len_q[i]) begin
      total++;
      if (lat_len_q[i] != 1 || oe_len_q[i] != ON_CYCLES) begin
        bad++;
        $display("FAIL const_width%0d: lat=%0d oe_low=%0d required 1 %0d", i, lat_len_q[i], oe_len_q[i], ON_CYCLES);
      end
    end
  endtask

  task automatic test_col_pattern();
    logic [ROW_W+DW-1:0] e;
    apply_reset();
    fill_mem(1);
    enable = 1'b1;
    wait_rows(2, 4 * ROW_PERIOD, "col");
    stop_scan("col");
    predict_rows(row_q.size());
    foreach (row_q[i]) begin
      e = exp_q.pop_front();
      total++;
      if ({row_q[i].addr, row_q[i].data} !== e || row_q[i].data !== 24'h042108) begin
        bad++;
        $display("FAIL col_order%0d: addr=%0d data=%h required addr=%0d data=%h",
                 i, row_q[i].addr, row_q[i].data, e[ROW_W+DW-1:DW], e[DW-1:0]);
      end
    end
    total++;
    if (ra_q.size() != 2 * COLS) begin
      bad++;
      $display("FAIL col_rd_addr_count: got %0d required %0d", ra_q.size(), 2 * COLS);
    end
    foreach (ra_q[i]) begin
      total++;
      if (ra_q[i] !== 4'(i)) begin
        bad++;
        $display("FAIL col_rd_addr%0d: got %0d required %0d", i, ra_q[i], i);
      end
    end
  endtask

  task automatic test_frame();
    logic [ROW_W+DW-1:0] e;
    apply_reset();
    fill_mem(2);
    enable = 1'b1;
    wait_rows(ROWS + 1, 8 * ROW_PERIOD, "frame");
    stop_scan("frame");
    predict_rows(row_q.size());
    foreach (row_q[i]) begin
      e = exp_q.pop_front();
      total++;
      if ({row_q[i].addr, row_q[i].data} !== e || row_q[i].edges != COLS) begin
        bad++;
        $display("FAIL frame_row%0d: addr=%0d edges=%0d data=%h required addr=%0d edges=%0d data=%h",
                 i, row_q[i].addr, row_q[i].edges, row_q[i].data, e[ROW_W+DW-1:DW], COLS, e[DW-1:0]);
      end
    end
    total++;
    if (fd_q.size() != 1 || busy_rise_q.size() != 1 || fd_q[0] - busy_rise_q[0] != FRAME) begin
      bad++;
      $display("FAIL frame_done_timing: pulses=%0d delay=%0d required 1 pulse delay=%0d", fd_q.size(),
               (fd_q.size() > 0 && busy_rise_q.size() > 0) ? fd_q[0] - busy_rise_q[0] : -1, FRAME);
    end
    total++;
    if (ghost_err != 0) begin
      bad++;
      $display("FAIL frame_addr_while_lit: changes=%0d required 0", ghost_err);
    end
    total++;
    if (ra_q.size() != (ROWS + 1) * COLS) begin
      bad++;
      $display("FAIL frame_rd_addr_count: got %0d required %0d", ra_q.size(), (ROWS + 1) * COLS);
    end
    foreach (ra_q[i]) begin
      total++;
      if (ra_q[i] !== 4'(i % (ROWS * COLS))) begin
        bad++;
        $display("FAIL frame_rd_addr%0d: got %0d required %0d", i, ra_q[i], i % (ROWS * COLS));
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [ROW_W+DW-1:0] e;
    apply_reset();
    fill_mem(2);
    enable = 1'b1;
    wait_rows(2, 4 * ROW_PERIOD, "drop");
    repeat ($urandom_range(1, 6)) @(negedge clk);
    stop_scan("drop");
    total++;
    if (row_q.size() != 2 || oe_len_q.size() != 2 || busy_fall_q.size() != 1) begin
      bad++;
      $display("FAIL drop_counts: rows=%0d oe_runs=%0d busy_falls=%0d required 2 2 1",
               row_q.size(), oe_len_q.size(), busy_fall_q.size());
    end else begin
      total++;
      if (oe_len_q[1] != ON_CYCLES || busy_fall_q[0] - row_q[1].cyc != ON_CYCLES + 2) begin
        bad++;
        $display("FAIL drop_row1_finish: oe_low=%0d busy_fall_after_latch=%0d required %0d %0d",
                 oe_len_q[1], busy_fall_q[0] - row_q[1].cyc, ON_CYCLES, ON_CYCLES + 2);
      end
    end
    repeat ($urandom_range(3, 30)) @(negedge clk);
    total++;
    if (row_q.size() != 2 || busy !== 1'b0) begin
      bad++;
      $display("FAIL drop_stays_idle: rows=%0d busy=%b required 2 0", row_q.size(), busy);
    end
    enable = 1'b1;
    wait_rows(3, 3 * ROW_PERIOD, "reenable");
    stop_scan("reenable");
    predict_rows(row_q.size());
    foreach (row_q[i]) begin
      e = exp_q.pop_front();
      total++;
      if ({row_q[i].addr, row_q[i].data} !== e) begin
        bad++;
        $display("FAIL drop_row%0d: addr=%0d data=%h required addr=%0d data=%h",
                 i, row_q[i].addr, row_q[i].data, e[ROW_W+DW-1:DW], e[DW-1:0]);
      end
    end
  endtask

  task automatic test_reset_mid_shift();
    apply_reset();
    fill_mem(2);
    enable = 1'b1;
    repeat ($urandom_range(2, 9)) @(negedge clk);
    total++;
    if (state_dbg !== SHIFT) begin
      bad++;
      $display("FAIL midshift_precondition: state=%0d required %0d", state_dbg, SHIFT);
    end
    #1 reset_n = 1'b0;
    #1;
    total++;
    if (outs !== RESET_VEC || state_dbg !== IDLE) begin
      bad++;
      $display("FAIL midshift_async_reset: outs=%b state=%0d required outs=%b state=%0d",
               outs, state_dbg, RESET_VEC, IDLE);
    end
    apply_reset();
  endtask

  task automatic test_random_enable();
    logic [ROW_W+DW-1:0] e;
    apply_reset();
    fill_mem(2);
    repeat (600) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0) enable = ~enable;
    end
    stop_scan("soak");
    predict_rows(row_q.size());
    foreach (row_q[i]) begin
      e = exp_q.pop_front();
      total++;
      if ({row_q[i].addr, row_q[i].data} !== e || row_q[i].edges != COLS ||
          oe_len_q[i] != ON_CYCLES || lat_len_q[i] != 1) begin
        bad++;
        $display("FAIL soak_row%0d: addr=%0d edges=%0d oe=%0d lat=%0d data=%h required addr=%0d edges=%0d oe=%0d lat=1 data=%h",
                 i, row_q[i].addr, row_q[i].edges, oe_len_q[i], lat_len_q[i], row_q[i].data,
                 e[ROW_W+DW-1:DW], COLS, ON_CYCLES, e[DW-1:0]);
      end
    end
    total++;
    if (fd_q.size() != row_q.size() / ROWS || ghost_err != 0) begin
      bad++;
      $display("FAIL soak_frames: frame_done=%0d ghost=%0d required %0d 0", fd_q.size(), ghost_err, row_q.size() / ROWS);
    end
  endtask

  initial begin
    for (int i = 0; i < ROWS * COLS; i++) mem[i] = '0;
    test_reset();
    test_idle();
    test_const_pattern();
    test_col_pattern();
    test_frame();
    test_enable_drop();
    test_reset_mid_shift();
    test_random_enable();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hub75_scan_ctrl.md
Name: hub75_scan_ctrl

Overview:
- Scan controller for a HUB75 RGB LED panel (dual-scan, 1 bit per colour per half).
- Reads pixel pairs from a synchronous frame buffer and shifts one row pair per scan slot.
- Drives the panel's r0/g0/b0/r1/g1/b1, shift clock, latch, output-enable and row address.
- Sits between the frame buffer and the registered panel-pin stage.

Parameters:
- COLS, 64, pixels per row (shift length); must be ≥2.
- COL_W, $clog2(COLS), column index width.
- ROW_W, 5, row-address width; row pairs = 2**ROW_W.
- ON_CYCLES, 256, clk cycles output-enable is held active per row; must be ≥1.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  run scanning; sampled only at row boundaries.
- rd_addr  out  ROW_W+COL_W  frame-buffer read address {row,col}.
- rd_data  in  6  pixel pair {r0,g0,b0,r1,g1,b1}, valid 1 cycle after rd_addr.
- r0, g0, b0, r1, g1, b1  out  1 each  panel colour data.
- sclk  out  1  panel shift clock.
- lat  out  1  panel latch, active high.
- oe_n  out  1  panel output enable, active low.
- addr  out  ROW_W  panel row address.
- busy  out  1  high in any state other than IDLE.
- frame_done  out  1  one-cycle pulse after the last row's BLANK completes.

Behaviour:
- Reset is asynchronous and takes effect immediately, including mid-row. All outputs are registered.
  - Reset values: sclk=0, lat=0, oe_n=1, addr=0, colours=0, rd_addr=0, busy=0, frame_done=0.
  - Internal row counter=0, state=IDLE.
- State sequence: IDLE → SHIFT → LATCH → DISPLAY → BLANK → (SHIFT | IDLE).
- IDLE:
  - oe_n=1.
  - enable=1 → SHIFT on the next cycle; row counter is kept (0 after reset).
- SHIFT: COLS+1 slots of 2 cycles each (slot s = 0..COLS), oe_n=1, lat=0.
  - Slot s, cycle 0: rd_addr={row,s} (s<COLS); sclk=0.
  - Slot s, cycle 1: rd_data captured into the colour outputs at the end of the cycle; sclk=1 only if s≥1.
  - Net effect: the rising sclk in slot s samples column s-1 data, which has been stable ≥1 full cycle.
  - Slot 0 produces no sclk pulse; slot COLS issues no new read (rd_addr held).
  - Exactly COLS sclk pulses per row; SHIFT lasts 2*(COLS+1) cycles.
- LATCH: 1 cycle; lat=1, addr←row, oe_n=1, sclk=0.
- DISPLAY: ON_CYCLES cycles with oe_n=0; lat=0.
- BLANK: 1 cycle; oe_n=1; row counter increments modulo 2**ROW_W.
  - If the incremented row wraps to 0, frame_done=1 in the next cycle (the first cycle of SHIFT or IDLE).
  - enable=1 → SHIFT; enable=0 → IDLE.
- Row period = 2*(COLS+1)+ON_CYCLES+2 cycles.
- addr changes only in LATCH, while oe_n=1 (no ghosting).
- enable deassert mid-row: the current row always completes through BLANK, then goes to IDLE.
  - Re-enable resumes at the next row, not row 0.
- Colour outputs hold their last shifted value outside SHIFT.

Decomposition:
- Package hub75_pkg:
  - scan_state_t enum (IDLE, SHIFT, LATCH, DISPLAY, BLANK).
  - Bit-index constants for rd_data (R0=5, G0=4, B0=3, R1=2, G1=1, B1=0).
- Sub-module hub75_shift_seq: slot/phase counter that generates rd_addr column, sclk, the capture strobe and a done flag.
- The top-level module holds the FSM, row and display counters, and the output registers.

Test Plan (COLS=4, ROW_W=2, ON_CYCLES=8 → row period 20, frame 80):
- Reset, then enable=1 with rd_data=6'b101010 for all addresses → per row exactly 4 sclk rising edges.
  - At each rising edge, {r0,g0,b0,r1,g1,b1}=101010.
  - lat high for exactly 1 cycle; oe_n low for exactly 8 cycles; row period 20 cycles.
- Buffer with rd_data = column index pattern (col0=000001 … col3=001000) → sclk edges 1..4 sample col0..col3 in order.
  - rd_addr sequence per row is {row,0..3}.
- Continuous run of 1 frame → addr sequence 0,1,2,3, changing only while oe_n=1.
  - frame_done pulses once, 80 cycles after the first SHIFT start.
  - Second frame starts at row 0.
- enable dropped during DISPLAY of row 1 → row 1 completes 8 oe_n-low cycles and BLANK, then busy=0.
  - Re-enable → next LATCH drives addr=2.
- reset_n asserted mid-SHIFT → outputs take reset values immediately (sclk=0, oe_n=1, addr=0, busy=0), with no clock edge required.
- enable held 0 from reset → no sclk, lat or oe_n activity for 100 cycles; busy=0.
